handshake_synchro: RTL and testbench

// - Req/ack toggle-handshake pulse synchronizer: transfers single-cycle events from a source

---
 rtl/bit_sync.sv | 24 ++
 rtl/handshake_synchro.sv | 84 ++++++++
 tb/tb_handshake_synchro.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/bit_sync.sv
// rtl/bit_sync.sv - clock-enabled 1-bit synchronizer chain, async active-high reset
module bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic i_rst,
    input  logic i_en,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_chain;

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_chain <= '0;
        end else if (i_en) begin
            r_chain <= {r_chain[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/handshake_synchro.sv
// rtl/handshake_synchro.sv - req/ack toggle pulse synchronizer into a tick-enabled slow domain
module handshake_synchro #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_fast,
    input  logic reset,
    input  logic clk_slow,
    input  logic pulse_in,
    output logic synchro_out,
    output logic synchro_busy
);

    logic w_slow_sync;
    logic w_tick;
    logic w_accept;
    logic w_req_sync;
    logic w_ack_sync;
    logic w_ev;

    logic r_slow_q;
    logic r_pulse_q;
    logic r_req;
    logic r_req_q;
    logic r_out;

    bit_sync #(.STAGES(SYNC_STAGES)) u_slow_sync (
        .clk   (clk_fast),
        .i_rst (reset),
        .i_en  (1'b1),
        .i_d   (clk_slow),
        .o_q   (w_slow_sync)
    );

    // clk_slow is data here: one tick per rising edge of its synchronized copy
    assign w_tick = w_slow_sync & ~r_slow_q;

    always_ff @(posedge clk_fast or posedge reset) begin
        if (reset) begin
            r_slow_q  <= 1'b0;
            r_pulse_q <= 1'b0;
            r_req     <= 1'b0;
        end else begin
            r_slow_q  <= w_slow_sync;
            r_pulse_q <= pulse_in;
            if (w_accept) begin
                r_req <= ~r_req;
            end
        end
    end

    assign w_accept = pulse_in & ~r_pulse_q & ~synchro_busy;

    bit_sync #(.STAGES(SYNC_STAGES)) u_req_sync (
        .clk   (clk_fast),
        .i_rst (reset),
        .i_en  (w_tick),
        .i_d   (r_req),
        .o_q   (w_req_sync)
    );

    assign w_ev = w_req_sync ^ r_req_q;

    always_ff @(posedge clk_fast or posedge reset) begin
        if (reset) begin
            r_req_q <= 1'b0;
            r_out   <= 1'b0;
        end else if (w_tick) begin
            r_req_q <= w_req_sync;
            r_out   <= w_ev;
        end
    end

    bit_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
        .clk   (clk_fast),
        .i_rst (reset),
        .i_en  (1'b1),
        .i_d   (w_req_sync),
        .o_q   (w_ack_sync)
    );

    assign synchro_out  = r_out;
    assign synchro_busy = r_req ^ w_ack_sync;

endmodule

// File: tb/tb_handshake_synchro.sv
// tb/tb_handshake_synchro.sv - randomized self-checking bench for handshake_synchro
module tb_handshake_synchro;

    localparam int BUSY_MAX = 11;

    logic clk_fast;
    logic clk_slow;
    logic reset;
    logic pulse_in;
    logic synchro_out;
    logic synchro_busy;

    int checks;
    int errors;
    int total_rises;
    int exp_total;
    logic prev_out;

    handshake_synchro #(.SYNC_STAGES(2)) dut (
        .clk_fast     (clk_fast),
        .reset        (reset),
        .clk_slow     (clk_slow),
        .pulse_in     (pulse_in),
        .synchro_out  (synchro_out),
        .synchro_busy (synchro_busy)
    );

    initial begin
        clk_fast = 1'b0;
        forever #10 clk_fast = ~clk_fast;
    end

    initial begin
        clk_slow = 1'b0;
        #10;
        forever begin
            clk_slow = 1'b1;
            #20;
            clk_slow = 1'b0;
            #20;
        end
    end

    always @(negedge clk_fast) begin
        if (synchro_out && !prev_out) total_rises++;
        prev_out <= synchro_out;
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference rule: a rising edge launches only if no launch happened within the busy window.
    function automatic int model_launches(input int width, input int second_off);
        int launches;
        int last;
        int edges[$];
        launches = 0;
        last = -1000;
        edges.push_back(0);
        if (width == 1 && second_off > 0) edges.push_back(second_off);
        foreach (edges[i]) begin
            if (edges[i] - last >= BUSY_MAX) begin
                launches++;
                last = edges[i];
            end
        end
        return launches;
    endfunction

    task automatic txn(input string tag, input int width, input int second_off, input int win);
        int rises;
        int first_k;
        int hi_width;
        int exp_n;
        logic prev;
        exp_n = model_launches(width, second_off);
        exp_total += exp_n;
        rises = 0;
        first_k = -1;
        hi_width = 0;
        prev = 1'b0;
        @(posedge clk_fast); #1;
        pulse_in = 1'b1;
        for (int c = 1; c <= win; c++) begin
            int k;
            @(posedge clk_fast); #1;
            pulse_in = (c < width) || (width == 1 && c == second_off);
            @(negedge clk_fast);
            k = c - 1;
            if (k == 0) check({tag, "_busy_up"}, int'(synchro_busy), 1);
            if (k == 10) check({tag, "_busy_down"}, int'(synchro_busy), 0);
            if (synchro_out && !prev) begin
                rises++;
                if (first_k < 0) first_k = k;
            end
            if (synchro_out && rises == 1) hi_width++;
            prev = synchro_out;
        end
        check({tag, "_count"}, rises, exp_n);
        check({tag, "_lat_ok"}, int'(first_k >= 5 && first_k <= 8), 1);
        check({tag, "_width"}, hi_width, 2);
    endtask

    initial begin
        int bad;
        int base;
        checks = 0;
        errors = 0;
        total_rises = 0;
        exp_total = 0;
        prev_out = 1'b0;
        pulse_in = 1'b0;

        // T1: reset quiet
        reset = 1'b1;
        #1;
        check("rst_out", int'(synchro_out), 0);
        check("rst_busy", int'(synchro_busy), 0);
        #29;
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_fast);
            if (synchro_out || synchro_busy) bad++;
        end
        check("rst_quiet", bad, 0);

        // T2: single pulse
        txn("single", 1, 0, 20);

        // T3: spaced train
        for (int i = 0; i < 5; i++) txn("train", 1, 0, 16);

        // T4: drop while busy, then a fresh pulse
        txn("drop", 1, 2, 20);
        txn("after_drop", 1, 0, 20);

        // T5: long pulse
        txn("long", 12, 0, 24);

        // T6: mid-flight reset
        base = total_rises;
        @(posedge clk_fast); #1;
        pulse_in = 1'b1;
        @(posedge clk_fast); #1;
        pulse_in = 1'b0;
        repeat (3) @(posedge clk_fast);
        #1;
        reset = 1'b1;
        #1;
        check("midrst_out", int'(synchro_out), 0);
        check("midrst_busy", int'(synchro_busy), 0);
        repeat (2) @(posedge clk_fast);
        #1;
        reset = 1'b0;
        repeat (20) @(negedge clk_fast);
        check("midrst_no_out", total_rises - base, 0);
        txn("post_rst", 1, 0, 20);

        // randomized transactions
        for (int i = 0; i < 20; i++) begin
            int w;
            int s;
            repeat ($urandom_range(0, 3)) @(posedge clk_fast);
            w = ($urandom_range(0, 2) == 0) ? int'($urandom_range(2, 12)) : 1;
            s = (w == 1 && $urandom_range(0, 1) == 1) ? int'($urandom_range(2, 4)) : 0;
            txn("rand", w, s, 24);
        end

        check("total_pulses", total_rises, exp_total);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
